dmem_responder: RTL and testbench

Data-memory responder for the 5-stage RV32I core. It is the slave end of the MEM-stage data port: it accepts the byte-masked address, write data, mask and write-enable produced in MEM, and returns the combinational load word. Stores are absorbed by a small in-order store buffer and drained into a single-port word array on cycles with no load. Loads see buffered stores via per-byte forwarding, youngest entry wins. A stall output back-pressures the pipeline when the buffer is full.

---
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory slave for the MEM stage: word array fronted by an in-order store buffer.
// Loads merge buffered stores per byte (youngest wins); stores drain on cycles without a load.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int SB_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wd,
  input  logic [3:0]  dmem_mask,
  input  logic        dmem_we,
  input  logic        dmem_re,
  output logic [31:0] dmem_rd,
  output logic        dmem_stall,
  output logic        sb_empty
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem     [DEPTH_WORDS];
  logic [AW-1:0] sb_idx  [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];
  logic [3:0]    sb_mask [SB_DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [AW-1:0] word_idx;
  logic          full, enq, drain;
  logic [31:0]   rd_merged;
  logic [PW-1:0] ptr;
  logic          unused_addr;

  assign word_idx    = dmem_addr[AW+1:2];
  assign unused_addr = ^{dmem_addr[31:AW+2], dmem_addr[1:0]};

  // A full buffer refuses the store even if a drain frees a slot on the same edge.
  assign full       = (count == CW'(SB_DEPTH));
  assign enq        = dmem_we & ~full;
  assign drain      = (count != '0) & ~dmem_re;
  assign dmem_stall = dmem_we & full;
  assign sb_empty   = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_idx[i]  <= '0;
        sb_data[i] <= '0;
        sb_mask[i] <= '0;
      end
    end else begin
      if (enq) begin
        sb_idx[tail]  <= word_idx;
        sb_data[tail] <= dmem_wd;
        sb_mask[tail] <= dmem_mask;
        tail          <= tail + 1'b1;
      end
      if (drain) begin
        head <= head + 1'b1;
      end
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The array only ever sees the head entry, so its single port never conflicts with loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_mask[head][b]) begin
          mem[sb_idx[head]][8*b +: 8] <= sb_data[head][8*b +: 8];
        end
      end
    end
  end

  // Walk oldest to youngest so a later matching entry overwrites an earlier one's bytes.
  always_comb begin
    rd_merged = mem[word_idx];
    ptr       = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      ptr = head + PW'(k);
      if ((CW'(k) < count) && (sb_idx[ptr] == word_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_mask[ptr][b]) begin
            rd_merged[8*b +: 8] = sb_data[ptr][8*b +: 8];
          end
        end
      end
    end
  end

  assign dmem_rd = rd_merged;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: forwarding, merge, full-buffer stall,
// address aliasing and reset flush.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wd;
  logic [3:0]  dmem_mask;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] dmem_rd;
  logic        dmem_stall;
  logic        sb_empty;

  int nChecks = 0;
  int nFails  = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .SB_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .dmem_addr  (dmem_addr),
    .dmem_wd    (dmem_wd),
    .dmem_mask  (dmem_mask),
    .dmem_we    (dmem_we),
    .dmem_re    (dmem_re),
    .dmem_rd    (dmem_rd),
    .dmem_stall (dmem_stall),
    .sb_empty   (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] mask);
    @(negedge clk);
    dmem_we   = we;
    dmem_re   = re;
    dmem_addr = addr;
    dmem_wd   = wd;
    dmem_mask = mask;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    nChecks++;
    if (dmem_rd !== 32'h0) begin nFails++; $display("[TB] FAIL reset_rd: got %h expected %h", dmem_rd, 32'h0); end
    nChecks++;
    if (sb_empty !== 1'b1) begin nFails++; $display("[TB] FAIL reset_empty: got %b expected 1", sb_empty); end
    nChecks++;
    if (dmem_stall !== 1'b0) begin nFails++; $display("[TB] FAIL reset_stall: got %b expected 0", dmem_stall); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_forward;
    drive(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 4'b1111);
    drive(1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
    nChecks++;
    if (dmem_rd !== 32'hDEAD_BEEF) begin nFails++; $display("[TB] FAIL fwd_rd: got %h expected %h", dmem_rd, 32'hDEAD_BEEF); end
    nChecks++;
    if (sb_empty !== 1'b0) begin nFails++; $display("[TB] FAIL fwd_notempty: got %b expected 0", sb_empty); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nChecks++;
    if (sb_empty !== 1'b1) begin nFails++; $display("[TB] FAIL fwd_drained: got %b expected 1", sb_empty); end
    drive(1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
    nChecks++;
    if (dmem_rd !== 32'hDEAD_BEEF) begin nFails++; $display("[TB] FAIL fwd_array: got %h expected %h", dmem_rd, 32'hDEAD_BEEF); end
    drive(1'b0, 1'b1, 32'h44, 32'h0, 4'h0);
    nChecks++;
    if (dmem_rd !== 32'h0) begin nFails++; $display("[TB] FAIL fwd_neighbor: got %h expected %h", dmem_rd, 32'h0); end
  endtask

  task automatic test_merge;
    drive(1'b1, 1'b0, 32'h80, 32'h1111_1111, 4'b1111);
    drive(1'b1, 1'b0, 32'h80, 32'h0000_2200, 4'b0010);
    drive(1'b1, 1'b0, 32'h80, 32'h3300_0000, 4'b1000);
    drive(1'b0, 1'b1, 32'h80, 32'h0, 4'h0);
    nChecks++;
    if (dmem_rd !== 32'h3311_2211) begin nFails++; $display("[TB] FAIL merge_rd: got %h expected %h", dmem_rd, 32'h3311_2211); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b0, 1'b1, 32'h80, 32'h0, 4'h0);
    nChecks++;
    if (dmem_rd !== 32'h3311_2211) begin nFails++; $display("[TB] FAIL merge_array: got %h expected %h", dmem_rd, 32'h3311_2211); end
    nChecks++;
    if (sb_empty !== 1'b1) begin nFails++; $display("[TB] FAIL merge_empty: got %b expected 1", sb_empty); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [5];
    logic [31:0] datas [5];
    for (int i = 0; i < 5; i++) begin
      addrs[i] = 32'h200 + 32'(4 * i);
      datas[i] = 32'hC0DE_0000 + 32'(i * 32'h101);
    end
    // Loads held on the port each cycle, so the four stores all queue.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, addrs[i], datas[i], 4'b1111);
      nChecks++;
      if (dmem_stall !== 1'b0) begin nFails++; $display("[TB] FAIL fill_stall%0d: got %b expected 0", i, dmem_stall); end
    end
    drive(1'b1, 1'b1, addrs[4], datas[4], 4'b1111);
    nChecks++;
    if (dmem_stall !== 1'b1) begin nFails++; $display("[TB] FAIL full_stall_load: got %b expected 1", dmem_stall); end
    drive(1'b1, 1'b0, addrs[4], datas[4], 4'b1111);
    nChecks++;
    if (dmem_stall !== 1'b1) begin nFails++; $display("[TB] FAIL full_stall_drain: got %b expected 1", dmem_stall); end
    drive(1'b1, 1'b0, addrs[4], datas[4], 4'b1111);
    nChecks++;
    if (dmem_stall !== 1'b0) begin nFails++; $display("[TB] FAIL retry_stall: got %b expected 0", dmem_stall); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, addrs[i], 32'h0, 4'h0);
      nChecks++;
      if (dmem_rd !== datas[i]) begin nFails++; $display("[TB] FAIL b2b_fwd%0d: got %h expected %h", i, dmem_rd, datas[i]); end
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nChecks++;
    if (sb_empty !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_empty: got %b expected 1", sb_empty); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, addrs[i], 32'h0, 4'h0);
      nChecks++;
      if (dmem_rd !== datas[i]) begin nFails++; $display("[TB] FAIL b2b_array%0d: got %h expected %h", i, dmem_rd, datas[i]); end
    end
  endtask

  task automatic test_alias;
    drive(1'b1, 1'b0, 32'h1000, 32'hA5A5_A5A5, 4'b1111);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    nChecks++;
    if (dmem_rd !== 32'hA5A5_A5A5) begin nFails++; $display("[TB] FAIL alias_fwd: got %h expected %h", dmem_rd, 32'hA5A5_A5A5); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    nChecks++;
    if (dmem_rd !== 32'hA5A5_A5A5) begin nFails++; $display("[TB] FAIL alias_array: got %h expected %h", dmem_rd, 32'hA5A5_A5A5); end
  endtask

  task automatic test_reset_flush;
    drive(1'b1, 1'b1, 32'h300, 32'h1234_5678, 4'b1111);
    drive(1'b1, 1'b1, 32'h304, 32'h9ABC_DEF0, 4'b1111);
    drive(1'b1, 1'b1, 32'h308, 32'h0F0F_0F0F, 4'b1111);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nChecks++;
    if (sb_empty !== 1'b0) begin nFails++; $display("[TB] FAIL flush_pending: got %b expected 0", sb_empty); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h300 + 32'(4 * i), 32'h0, 4'h0);
      nChecks++;
      if (dmem_rd !== 32'h0) begin nFails++; $display("[TB] FAIL flush_rd%0d: got %h expected %h", i, dmem_rd, 32'h0); end
    end
    nChecks++;
    if (sb_empty !== 1'b1) begin nFails++; $display("[TB] FAIL flush_empty: got %b expected 1", sb_empty); end
    drive(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    nChecks++;
    if (dmem_rd !== 32'h0) begin nFails++; $display("[TB] FAIL flush_word0: got %h expected %h", dmem_rd, 32'h0); end
  endtask

  initial begin
    reset     = 1'b0;
    dmem_we   = 1'b0;
    dmem_re   = 1'b0;
    dmem_addr = '0;
    dmem_wd   = '0;
    dmem_mask = '0;
    test_reset();
    test_forward();
    test_merge();
    test_back_to_back();
    test_alias();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
